// File: rtl/uart_tx_sequencer.sv
// Byte FIFO feeding a tx_uart via a start_tx/tx_done handshake, with idle gap and tx_done watchdog.
// Optional UART_TX_SEQ_STATS_EN adds the o_sent_cnt frame counter.
module uart_tx_sequencer #(
  parameter int G_DATA_WIDTH      = 8,
  parameter int G_FIFO_ADDR_WIDTH = 4,
  parameter int G_GAP_CYCLES      = 16,
  parameter int G_TIMEOUT_CYCLES  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_en,
  input  logic [G_DATA_WIDTH-1:0]      i_wr_data,
  input  logic                         i_enable,
  input  logic                         i_clr_err,
  input  logic                         i_tx_done,
  output logic                         o_start_tx,
  output logic [G_DATA_WIDTH-1:0]      o_tx_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [G_FIFO_ADDR_WIDTH:0]   o_level,
  output logic                         o_busy,
  output logic                         o_ovf_err,
  output logic                         o_timeout_err
`ifdef UART_TX_SEQ_STATS_EN
  ,
  output logic [15:0]                  o_sent_cnt
`endif
);

  // state      | meaning
  // ST_IDLE    | waiting for enable and a queued byte
  // ST_START   | one-cycle start_tx pulse to tx_uart
  // ST_WAIT_DONE | waiting for tx_done rising edge (watchdog running)
  // ST_GAP     | idle gap before the next frame may start

  localparam int LP_AW    = G_FIFO_ADDR_WIDTH;
  localparam int LP_DEPTH = 1 << LP_AW;
  localparam logic [LP_AW:0] LP_FULL_LVL = (LP_AW+1)'(LP_DEPTH);
  localparam logic [31:0] LP_GAP_LAST = (G_GAP_CYCLES > 0) ? 32'(G_GAP_CYCLES - 1) : 32'd0;
  localparam logic [31:0] LP_TO_LAST  = (G_TIMEOUT_CYCLES > 0) ? 32'(G_TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT_DONE, ST_GAP} t_state;

  t_state                  r_state;
  t_state                  w_next;
  logic [G_DATA_WIDTH-1:0] r_mem [LP_DEPTH];
  logic [LP_AW:0]          r_wr_ptr;
  logic [LP_AW:0]          r_rd_ptr;
  logic [LP_AW:0]          w_level;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr_ok;
  logic                    w_pop;
  logic                    w_busy;
  logic                    w_done_re;
  logic                    w_to_expire;
  logic                    r_tx_done_q;
  logic [31:0]             r_cnt;
  logic                    r_start_tx;
  logic [G_DATA_WIDTH-1:0] r_tx_data;
  logic                    r_ovf_err;
  logic                    r_timeout_err;

  assign w_level     = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_level == LP_FULL_LVL);
  assign w_empty     = (w_level == '0);
  assign w_wr_ok     = i_wr_en & ~w_full;
  assign w_done_re   = i_tx_done & ~r_tx_done_q;
  // done_re has priority over an expiry in the same cycle
  assign w_to_expire = (G_TIMEOUT_CYCLES > 0) && (r_state == ST_WAIT_DONE) &&
                       !w_done_re && (r_cnt == LP_TO_LAST);

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr[LP_AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tx_done_q <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_tx_done_q <= i_tx_done;
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_data <= r_mem[r_rd_ptr[LP_AW-1:0]];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (i_enable && !w_empty) w_next = ST_START;
      ST_START:     w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (w_done_re)        w_next = (G_GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        else if (w_to_expire) w_next = ST_IDLE;
      end
      ST_GAP:       if (r_cnt == LP_GAP_LAST) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    w_pop  = 1'b0;
    w_busy = 1'b1;
    if (r_state == ST_IDLE) begin
      w_busy = 1'b0;
      w_pop  = i_enable & ~w_empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_start_tx    <= 1'b0;
      r_ovf_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_start_tx <= (w_next == ST_START);
      if (r_state != w_next)
        r_cnt <= '0;
      else if ((r_state == ST_GAP) || ((r_state == ST_WAIT_DONE) && (G_TIMEOUT_CYCLES > 0)))
        r_cnt <= r_cnt + 1'b1;
      if (i_wr_en && w_full) r_ovf_err <= 1'b1;
      else if (i_clr_err)    r_ovf_err <= 1'b0;
      if (w_to_expire)       r_timeout_err <= 1'b1;
      else if (i_clr_err)    r_timeout_err <= 1'b0;
    end
  end

`ifdef UART_TX_SEQ_STATS_EN
  logic [15:0] r_sent_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_sent_cnt <= '0;
    else if ((r_state == ST_WAIT_DONE) && w_done_re) r_sent_cnt <= r_sent_cnt + 1'b1;
    else if (i_clr_err)                              r_sent_cnt <= '0;
  end
  assign o_sent_cnt = r_sent_cnt;
`endif

  assign o_start_tx    = r_start_tx;
  assign o_tx_data     = r_tx_data;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_level       = w_level;
  assign o_busy        = w_busy;
  assign o_ovf_err     = r_ovf_err;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer (gap 16, watchdog 100); stats checks when UART_TX_SEQ_STATS_EN is defined.
module tb_uart_tx_sequencer;

  logic       clk;
  logic       rst_n;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       i_enable;
  logic       i_clr_err;
  logic       i_tx_done;
  logic       o_start_tx;
  logic [7:0] o_tx_data;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_level;
  logic       o_busy;
  logic       o_ovf_err;
  logic       o_timeout_err;
`ifdef UART_TX_SEQ_STATS_EN
  logic [15:0] o_sent_cnt;
`endif

  uart_tx_sequencer #(
    .G_DATA_WIDTH(8), .G_FIFO_ADDR_WIDTH(4), .G_GAP_CYCLES(16), .G_TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .i_enable(i_enable), .i_clr_err(i_clr_err), .i_tx_done(i_tx_done),
    .o_start_tx(o_start_tx), .o_tx_data(o_tx_data), .o_full(o_full),
    .o_empty(o_empty), .o_level(o_level), .o_busy(o_busy),
    .o_ovf_err(o_ovf_err), .o_timeout_err(o_timeout_err)
`ifdef UART_TX_SEQ_STATS_EN
    , .o_sent_cnt(o_sent_cnt)
`endif
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_starts = 0;
  int         last_push_edge = 0;
  int         last_done_edge = 0;
  bit         done_valid = 0;
  bit         auto_done  = 0;
  int         done_delay = 5;
  bit         chk_lat = 0;
  bit         chk_gap = 0;
  logic       prev_start = 0;
  logic [7:0] sb_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL global_timeout cycles=%0d limit=50000", cyc);
    $fatal(1, "simulation did not terminate");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    i_wr_en   = 1'b1;
    i_wr_data = b;
    if (accepted) sb_q.push_back(b);
    tick;
    last_push_edge = cyc;
    i_wr_en = 1'b0;
  endtask

  task automatic pulse_clr;
    i_clr_err = 1'b1;
    tick;
    i_clr_err = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while ((o_busy || !o_empty) && k < bound) begin
      tick;
      k++;
    end
    if (k >= bound) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_bound busy=%0b empty=%0b waited=%0d limit=%0d", name, o_busy, o_empty, k, bound);
    end
  endtask

  // tx_uart stand-in: one-cycle tx_done a fixed delay after each start
  initial begin
    i_tx_done = 1'b0;
    forever begin
      tick;
      if (o_start_tx && auto_done) begin
        repeat (done_delay) tick;
        i_tx_done = 1'b1;
        last_done_edge = cyc + 1;
        done_valid = 1;
        tick;
        i_tx_done = 1'b0;
      end
    end
  end

  // monitor: every start pulse pops the scoreboard
  initial begin
    logic [7:0] exp;
    forever begin
      tick;
      if (o_start_tx) begin
        n_starts++;
        check("start_one_cycle", {31'd0, prev_start}, 32'd0);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start data=0x%0h expected no start (cycle %0d)", o_tx_data, cyc);
        end else begin
          exp = sb_q.pop_front();
          check("tx_data", {24'd0, o_tx_data}, {24'd0, exp});
        end
        if (chk_lat) check("start_latency", cyc - last_push_edge, 32'd1);
        if (chk_gap && done_valid) check("gap_after_done", cyc - last_done_edge, 32'd17);
      end
      prev_start = o_start_tx;
    end
  end

  initial begin
    int s_edge;
    int k;
    int starts_before;
    rst_n = 1'b0; i_wr_en = 1'b0; i_wr_data = 8'h00;
    i_enable = 1'b0; i_clr_err = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;

    // reset state
    check("rst_empty", {31'd0, o_empty}, 32'd1);
    check("rst_full", {31'd0, o_full}, 32'd0);
    check("rst_level", {27'd0, o_level}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_start", {31'd0, o_start_tx}, 32'd0);
    check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
    check("rst_errs", {30'd0, o_ovf_err, o_timeout_err}, 32'd0);

    // 1: single byte, latency
    i_enable = 1'b1; auto_done = 1; chk_lat = 1;
    push(8'hA5, 1);
    check("t1_level_after_push", {27'd0, o_level}, 32'd1);
    wait_idle("t1_idle", 200);
    chk_lat = 0;
    check("t1_empty", {31'd0, o_empty}, 32'd1);
    check("t1_sb_drained", sb_q.size(), 32'd0);

    // 2: three bytes back to back, gap measured from each done_re
    done_valid = 0; chk_gap = 1;
    push(8'h01, 1);
    push(8'h02, 1);
    push(8'h03, 1);
    wait_idle("t2_idle", 400);
    chk_gap = 0;
    check("t2_empty", {31'd0, o_empty}, 32'd1);
    check("t2_sb_drained", sb_q.size(), 32'd0);

    // 3: overflow with enable low
    i_enable = 1'b0;
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), i < 16);
    check("t3_full", {31'd0, o_full}, 32'd1);
    check("t3_level", {27'd0, o_level}, 32'd16);
    check("t3_ovf", {31'd0, o_ovf_err}, 32'd1);
    check("t3_not_busy", {31'd0, o_busy}, 32'd0);
    pulse_clr;
    check("t3_ovf_cleared", {31'd0, o_ovf_err}, 32'd0);
    check("t3_level_kept", {27'd0, o_level}, 32'd16);
    i_enable = 1'b1;
    wait_idle("t3_drain", 2000);
    check("t3_sb_drained", sb_q.size(), 32'd0);
    check("t3_empty", {31'd0, o_empty}, 32'd1);

    // 4: watchdog, no tx_done
    auto_done = 0;
    push(8'h5A, 1);
    push(8'h6B, 1);
    k = 0;
    while (!o_start_tx && k < 50) begin tick; k++; end
    s_edge = cyc;
    k = 0;
    while (!o_timeout_err && k < 300) begin tick; k++; end
    // start cycle, then 100 cycles in WAIT_DONE
    check("t4_timeout_delay", cyc - s_edge, 32'd101);
    check("t4_timeout_flag", {31'd0, o_timeout_err}, 32'd1);
    check("t4_back_idle", {31'd0, o_busy}, 32'd0);
    tick;
    check("t4_next_start", {31'd0, o_start_tx}, 32'd1);
    wait_idle("t4_idle", 300);
    pulse_clr;
    check("t4_timeout_cleared", {31'd0, o_timeout_err}, 32'd0);
    check("t4_sb_drained", sb_q.size(), 32'd0);

    // 5: async reset during WAIT_DONE with 4 bytes queued
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1);
    repeat (5) tick;
    check("t5_pre_level", {27'd0, o_level}, 32'd4);
    check("t5_pre_busy", {31'd0, o_busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_level", {27'd0, o_level}, 32'd0);
    check("t5_rst_empty", {31'd0, o_empty}, 32'd1);
    check("t5_rst_busy", {31'd0, o_busy}, 32'd0);
    check("t5_rst_tx_data", {24'd0, o_tx_data}, 32'd0);
    check("t5_rst_start", {31'd0, o_start_tx}, 32'd0);
    sb_q.delete();
    tick;
    tick;
    rst_n = 1'b1;
    starts_before = n_starts;
    repeat (50) tick;
    check("t5_no_start_after_rst", n_starts - starts_before, 32'd0);
    auto_done = 1;
    chk_lat = 1;
    push(8'h77, 1);
    wait_idle("t5_idle", 200);
    chk_lat = 0;
    check("t5_sb_drained", sb_q.size(), 32'd0);

`ifdef UART_TX_SEQ_STATS_EN
    // 6: frame counter
    check("t6_cnt_one", {16'd0, o_sent_cnt}, 32'd1);
    pulse_clr;
    check("t6_cnt_clr0", {16'd0, o_sent_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 1);
    wait_idle("t6_idle", 1000);
    check("t6_cnt_five", {16'd0, o_sent_cnt}, 32'd5);
    pulse_clr;
    check("t6_cnt_clr", {16'd0, o_sent_cnt}, 32'd0);
`endif

    repeat (5) tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
